gpi_conditioner: RTL and testbench

Input-conditioning stage directly upstream of the GPIO register block. Takes raw asynchronous board pins, synchronises and debounces each bit, and presents the clean vector that the GPIO block exposes as its read-only input word. Optionally captures rising edges into sticky, write-one-to-clear flags and raises a level interrupt to the CPU.

---
 rtl/gpio_pkg.sv | 7 +
 rtl/gpi_conditioner_tick_gen.sv | 15 +
 rtl/gpi_conditioner.sv | 58 +++++
 tb/tb_gpi_conditioner.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared GPIO width, debounce defaults and word type.
package gpio_pkg;
   localparam int GPIO_WIDTH   = 32;
   localparam int GPI_PRESCALE = 1000;
   localparam int GPI_STABLE   = 3;
   typedef logic [GPIO_WIDTH-1:0] gpio_word_t;
endpackage

// File: rtl/gpi_conditioner_tick_gen.sv
// tick_gen: free-running prescaler, one-cycle tick every PRESCALE clocks.
module tick_gen #(
   parameter int PRESCALE = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = $clog2(PRESCALE);
   logic [CW-1:0] cnt;
   assign tick = (cnt == CW'(PRESCALE - 1));
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/gpi_conditioner.sv
// gpi_conditioner: synchronise and debounce raw pins; optional rising-edge flags and irq.
// Build with GPI_EDGE_IRQ_EN defined to get edge_flags/irq; otherwise they are tied to 0.
module gpi_conditioner
   import gpio_pkg::*;
#(
   parameter int WIDTH    = GPIO_WIDTH,
   parameter int PRESCALE = GPI_PRESCALE,
   parameter int STABLE   = GPI_STABLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pin_in,
   input  logic             clr_we,
   input  logic [WIDTH-1:0] clr_mask,
   output logic [WIDTH-1:0] gpi,
   output logic [WIDTH-1:0] edge_flags,
   output logic             irq
);
   logic             tick, tick_d;
   logic [WIDTH-1:0] sync1, sync, gpi_nxt;
   tick_gen #(.PRESCALE(PRESCALE)) u_tick (.clk(clk), .rst(rst), .tick(tick));
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sync1  <= '0;
         sync   <= '0;
         tick_d <= 1'b0;
         gpi    <= '0;
      end else begin
         sync1  <= pin_in;
         sync   <= sync1;
         tick_d <= tick;
         gpi    <= gpi_nxt;
      end
   // acceptance is evaluated the cycle after the sample shift, so history is settled
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [STABLE-1:0] hist;
      always_ff @(posedge clk or negedge rst)
         if (!rst) hist <= '0;
         else if (tick) hist <= {hist[STABLE-2:0], sync[i]};
      assign gpi_nxt[i] = (tick_d && (&hist || ~|hist)) ? hist[0] : gpi[i];
   end
`ifdef GPI_EDGE_IRQ_EN
   // set term is OR-ed after the clear so a simultaneous rise wins
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         edge_flags <= '0;
         irq        <= 1'b0;
      end else begin
         edge_flags <= (edge_flags & ~(clr_we ? clr_mask : '0)) | (gpi_nxt & ~gpi);
         irq        <= |edge_flags;
      end
`else
   logic unused_clr;
   assign unused_clr = ^{clr_we, clr_mask};
   assign edge_flags = '0;
   assign irq        = 1'b0;
`endif
endmodule

// File: tb/tb_gpi_conditioner.sv
// tb_gpi_conditioner: directed + random stimulus against a pin-log reference model.
module tb_gpi_conditioner;
   localparam int P = 4;
   localparam int S = 3;
   localparam int W = 32;
`ifdef GPI_EDGE_IRQ_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif
   logic         clk = 1'b0, rst = 1'b0, clr_we = 1'b0, irq;
   logic [W-1:0] pin_in = '0, clr_mask = '0, gpi, edge_flags;
   int           checks = 0, failures = 0;
   bit           chk_en = 1'b0;

   always #5 clk = ~clk;

   gpi_conditioner #(.WIDTH(W), .PRESCALE(P), .STABLE(S)) dut (
      .clk(clk), .rst(rst), .pin_in(pin_in), .clr_we(clr_we), .clr_mask(clr_mask),
      .gpi(gpi), .edge_flags(edge_flags), .irq(irq)
   );

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: log of pin values per edge since reset; tick edges are the multiples of P,
   // each sampling the pin seen two edges earlier, and the level is accepted one edge later.
   logic [W-1:0] pins [0:16383];
   int           n = 0;
   logic [W-1:0] m_gpi = '0, m_flags = '0;
   logic         m_irq = 1'b0;

   function automatic logic [W-1:0] samp(input int idx);
      return (idx < 1) ? '0 : pins[idx];
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n = 0;
         m_gpi = '0;
         m_flags = '0;
         m_irq = 1'b0;
      end else begin : upd
         logic [W-1:0] old_g, hi, lo;
         n++;
         if (n < 16384) pins[n] = pin_in;
         old_g = m_gpi;
         m_irq = |m_flags;
         if (n > P && n % P == 1) begin
            hi = '1;
            lo = '1;
            for (int k = 0; k < S; k++) begin
               hi &= samp(n - 3 - k * P);
               lo &= ~samp(n - 3 - k * P);
            end
            m_gpi = (m_gpi | hi) & ~lo;
         end
         m_flags = (m_flags & ~(clr_we ? clr_mask : '0)) | (m_gpi & ~old_g);
      end
   end

   always @(negedge clk) if (chk_en) begin
      check("model_gpi", gpi, m_gpi);
      check("model_flags", edge_flags, EN ? m_flags : '0);
      check("model_irq", W'(irq), W'(EN & m_irq));
   end

   task automatic cyc(input int c);
      repeat (c) @(negedge clk);
   endtask

   initial begin
      int k, r;
      chk_en = 1'b1;
      cyc(3);
      @(posedge clk); #2 rst = 1'b1;
      // idle after reset
      repeat (20) begin
         @(negedge clk);
         check("idle_gpi", gpi, '0);
         check("idle_flags", edge_flags, '0);
         check("idle_irq", W'(irq), '0);
      end
      // bit 0 step latency
      pin_in[0] = 1'b1;
      k = 0;
      while (k < 30 && !gpi[0]) begin @(negedge clk); k++; end
      check("lat0_in_12_15", W'(k >= 12 && k <= 15), W'(1));
      check("flag0_same_edge", W'(edge_flags[0]), W'(EN));
      check("irq_not_yet", W'(irq), '0);
      @(negedge clk);
      check("irq_lag", W'(irq), W'(EN));
      // short pulses at every tick phase
      for (int ph = 0; ph < P; ph++) begin
         while (n % P != ph) @(negedge clk);
         pin_in[5] = 1'b1;
         cyc(3);
         pin_in[5] = 1'b0;
         cyc(20);
         check("pulse_gpi5", W'(gpi[5]), '0);
         check("pulse_flag5", W'(edge_flags[5]), '0);
      end
      // selective clear
      pin_in[3] = 1'b1;
      cyc(20);
      check("flags_0_3", edge_flags, EN ? W'(32'h9) : '0);
      clr_we = 1'b1; clr_mask = 32'h1;
      cyc(1);
      clr_we = 1'b0;
      check("clr0", edge_flags, EN ? W'(32'h8) : '0);
      clr_we = 1'b1; clr_mask = 32'h8;
      cyc(1);
      clr_we = 1'b0;
      check("clr3", edge_flags, '0);
      check("irq_still", W'(irq), W'(EN));
      cyc(1);
      check("irq_fall", W'(irq), '0);
      // clear coinciding with rise: set wins
      r = n + 3 + (S - 1) * P;
      r = ((r + P - 1) / P) * P + 1;
      pin_in[2] = 1'b1;
      while (n < r - 1) @(negedge clk);
      check("gpi2_before", W'(gpi[2]), '0);
      clr_we = 1'b1; clr_mask = 32'h4;
      @(negedge clk);
      clr_we = 1'b0;
      check("gpi2_rise", W'(gpi[2]), W'(1));
      check("set_wins2", W'(edge_flags[2]), W'(EN));
      // reset mid-debounce
      pin_in[7] = 1'b1;
      cyc(5);
      @(posedge clk); #2 rst = 1'b0;
      #1 check("rst_gpi", gpi, '0);
      check("rst_flags", edge_flags, '0);
      check("rst_irq", W'(irq), '0);
      cyc(3);
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk);
      k = 0;
      while (k < 30 && !gpi[7]) begin @(negedge clk); k++; end
      check("lat7_in_12_15", W'(k >= 12 && k <= 15), W'(1));
      check("flag7_after_rst", W'(edge_flags[7]), W'(EN));
      // random traffic
      repeat (2000) begin
         @(negedge clk);
         pin_in ^= $urandom & $urandom & $urandom & $urandom & $urandom & $urandom;
         clr_we = ($urandom % 8 == 0);
         clr_mask = $urandom;
      end
      clr_we = 1'b0;
      cyc(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
